alarm_tone_gen: RTL

Downstream consumer of the alarm-enable level (aud_en) from the alarm sound controller. While aud_en is high, it plays a fixed 8-step melody in a loop and drives a square wave on aud_out to the buzzer/speaker pin. When aud_en is low, the output is silent. It also reports its progress (step, loop count) for debug and LED display.

---
 rtl/alarm_tone_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm melody player: loops a fixed 8-step tune as a square wave on aud_out
// while aud_en is high, with a silent gap after every step.
module alarm_tone_gen #(
    parameter int HP_BASE  = 3125,
    parameter int TICK_DIV = 6250000,
    parameter int GAP_CLKS = 625000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       aud_en,
    output logic       aud_out,
    output logic       playing,
    output logic [2:0] step_idx,
    output logic [7:0] loop_cnt
);

    localparam int HW = $clog2(HP_BASE * 8);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    typedef struct packed {
        logic [2:0] code;
        logic [2:0] dur;
    } note_t;

    function automatic note_t melody(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{code: 3'd1, dur: 3'd2};
            3'd1:    return '{code: 3'd3, dur: 3'd2};
            3'd2:    return '{code: 3'd5, dur: 3'd2};
            3'd3:    return '{code: 3'd0, dur: 3'd1};
            3'd4:    return '{code: 3'd5, dur: 3'd1};
            3'd5:    return '{code: 3'd3, dur: 3'd1};
            3'd6:    return '{code: 3'd1, dur: 3'd2};
            default: return '{code: 3'd0, dur: 3'd4};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [7:0]    loop_q, loop_d;
    logic [HW-1:0] hp_q, hp_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    dur_q, dur_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          aud_q, aud_d;

    note_t         note;
    logic [HW-1:0] hp_last;
    logic          tick_last;
    logic          step_end;
    logic [7:0]    loop_next;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d = state_q;
        step_d  = step_q;
        loop_d  = loop_q;
        hp_d    = hp_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        aud_d   = aud_q;

        note      = melody(step_q);
        hp_last   = HW'(HP_BASE * (9 - int'(note.code)) - 1);
        tick_last = (tick_q == TW'(TICK_DIV - 1));
        step_end  = tick_last && (dur_q == note.dur - 3'd1);
        // Loop count advances only on the 7 -> 0 wrap and sticks at 255.
        loop_next = (step_q == 3'd7 && loop_q != 8'hFF) ? loop_q + 8'd1 : loop_q;

        case (state_q)
            IDLE: begin
                if (aud_en) begin
                    state_d = PLAY;
                    step_d  = '0;
                    loop_d  = '0;
                    hp_d    = '0;
                    tick_d  = '0;
                    dur_d   = '0;
                    gap_d   = '0;
                    aud_d   = 1'b0;
                end
            end
            PLAY: begin
                if (!aud_en) begin
                    state_d = IDLE;
                    aud_d   = 1'b0;
                end else if (step_end) begin
                    hp_d   = '0;
                    tick_d = '0;
                    dur_d  = '0;
                    gap_d  = '0;
                    aud_d  = 1'b0;
                    if (GAP_CLKS == 0) begin
                        step_d = step_q + 3'd1;
                        loop_d = loop_next;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    if (tick_last) begin
                        tick_d = '0;
                        dur_d  = dur_q + 3'd1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    // Rests keep hp_cnt parked at 0 and the output low.
                    if (note.code != 3'd0) begin
                        if (hp_q == hp_last) begin
                            hp_d  = '0;
                            aud_d = ~aud_q;
                        end else begin
                            hp_d = hp_q + HW'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (!aud_en) begin
                    state_d = IDLE;
                    aud_d   = 1'b0;
                end else if (gap_q == GW'(GAP_CLKS - 1)) begin
                    state_d = PLAY;
                    gap_d   = '0;
                    step_d  = step_q + 3'd1;
                    loop_d  = loop_next;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                aud_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            step_q  <= '0;
            loop_q  <= '0;
            hp_q    <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            aud_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            hp_q    <= hp_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            aud_q   <= aud_d;
        end
    end

    assign aud_out  = aud_q;
    assign playing  = (state_q != IDLE);
    assign step_idx = step_q;
    assign loop_cnt = loop_q;

endmodule
